// File: rtl/fc_func_pkg.sv
// Shared state types for the layer controllers; fc_func imports its FSM encoding from here.
package fc_func_pkg;

    typedef enum logic [1:0] {
        s_conv_ctrl_idle    = 2'd0,
        s_conv_ctrl_load    = 2'd1,
        s_conv_ctrl_compute = 2'd2,
        s_conv_ctrl_store   = 2'd3
    } t_conv_ctrl_state;

    // idle: await start | sum: add tile partials | write: emit one neuron | notify: hand off to next layer
    typedef enum logic [1:0] {
        s_fc_func_idle   = 2'd0,
        s_fc_func_sum    = 2'd1,
        s_fc_func_write  = 2'd2,
        s_fc_func_notify = 2'd3
    } t_fc_func_state;

endpackage

// File: rtl/fc_func_adder.sv
// Combinational signed sum of V_CIM_TILES partial sums, each sign-extended to SUM_WIDTH.
module fc_func_adder #(
    parameter int V_CIM_TILES = 98,
    parameter int ACC_WIDTH   = 24,
    parameter int SUM_WIDTH   = ACC_WIDTH + $clog2(V_CIM_TILES)
) (
    input  logic [V_CIM_TILES*ACC_WIDTH-1:0] i_data,
    output logic signed [SUM_WIDTH-1:0]      o_sum
);

    always_comb begin
        o_sum = '0;
        for (int t = 0; t < V_CIM_TILES; t++) begin
            o_sum = o_sum + SUM_WIDTH'(signed'(i_data[t*ACC_WIDTH +: ACC_WIDTH]));
        end
    end

endmodule

// File: rtl/fc_func.sv
// Fully-connected output stage: sums CIM tile partials per neuron, requantises, writes the output buffer.
// Define FC_FUNC_RELU_EN for a ReLU + unsigned-saturating quantiser; default is signed saturation.
module fc_func
    import fc_func_pkg::*;
#(
    parameter int DATA_SIZE   = 8,
    parameter int XBAR_SIZE   = 128,
    parameter int V_CIM_TILES = 98,
    parameter int ACC_WIDTH   = 24,
    parameter int SHIFT       = 8,
    parameter int ADDR_WIDTH  = $clog2(XBAR_SIZE)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_start,
    output logic                               o_ready,
    output logic [ADDR_WIDTH-1:0]              o_cim_addr,
    input  logic [V_CIM_TILES*ACC_WIDTH-1:0]   i_cim_data,
    output logic                               o_obuf_we,
    output logic [ADDR_WIDTH-1:0]              o_obuf_addr,
    output logic [DATA_SIZE-1:0]               o_obuf_data,
    input  logic                               i_next_ready,
    output logic                               o_next_start
);

    localparam int SUM_WIDTH = ACC_WIDTH + $clog2(V_CIM_TILES);
    localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(XBAR_SIZE - 1);

    t_fc_func_state              r_state, w_next;
    logic [ADDR_WIDTH-1:0]       r_index;
    logic signed [SUM_WIDTH-1:0] r_sum;
    logic signed [SUM_WIDTH-1:0] w_sum;
    logic signed [SUM_WIDTH-1:0] w_shift;
    logic [DATA_SIZE-1:0]        w_quant;

    fc_func_adder #(
        .V_CIM_TILES (V_CIM_TILES),
        .ACC_WIDTH   (ACC_WIDTH),
        .SUM_WIDTH   (SUM_WIDTH)
    ) u_adder (
        .i_data (i_cim_data),
        .o_sum  (w_sum)
    );

`ifdef FC_FUNC_RELU_EN
    localparam logic signed [SUM_WIDTH-1:0] C_UMAX = SUM_WIDTH'((1 << DATA_SIZE) - 1);
    logic signed [SUM_WIDTH-1:0] w_relu;

    always_comb begin
        w_relu  = r_sum[SUM_WIDTH-1] ? '0 : r_sum;
        w_shift = w_relu >>> SHIFT;
        w_quant = (w_shift > C_UMAX) ? '1 : w_shift[DATA_SIZE-1:0];
    end
`else
    localparam logic signed [SUM_WIDTH-1:0] C_SMAX = SUM_WIDTH'((1 << (DATA_SIZE - 1)) - 1);
    localparam logic signed [SUM_WIDTH-1:0] C_SMIN = ~C_SMAX;

    always_comb begin
        w_shift = r_sum >>> SHIFT;
        if (w_shift > C_SMAX) begin
            w_quant = {1'b0, {(DATA_SIZE-1){1'b1}}};
        end else if (w_shift < C_SMIN) begin
            w_quant = {1'b1, {(DATA_SIZE-1){1'b0}}};
        end else begin
            w_quant = w_shift[DATA_SIZE-1:0];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= s_fc_func_idle;
            r_index <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == s_fc_func_idle && i_start) begin
                r_index <= '0;
            end
            if (r_state == s_fc_func_sum) begin
                r_sum <= w_sum;
            end
            if (r_state == s_fc_func_write && r_index != C_LAST) begin
                r_index <= r_index + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        o_ready      = 1'b0;
        o_obuf_we    = 1'b0;
        o_next_start = 1'b0;
        o_cim_addr   = r_index;
        o_obuf_addr  = r_index;
        o_obuf_data  = '0;
        case (r_state)
            s_fc_func_idle: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_next = s_fc_func_sum;
                end
            end
            s_fc_func_sum: begin
                w_next = s_fc_func_write;
            end
            s_fc_func_write: begin
                o_obuf_we   = 1'b1;
                o_obuf_data = w_quant;
                w_next      = (r_index == C_LAST) ? s_fc_func_notify : s_fc_func_sum;
            end
            s_fc_func_notify: begin
                if (i_next_ready) begin
                    o_next_start = 1'b1;
                    w_next       = s_fc_func_idle;
                end
            end
            default: begin
                w_next      = s_fc_func_idle;
                o_cim_addr  = '0;
                o_obuf_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fc_func.sv
// Bench for fc_func on a 4-neuron, 2-tile layer; reference quantiser honours FC_FUNC_RELU_EN.
module tb_fc_func;

    localparam int DATA_SIZE = 8;
    localparam int XBAR      = 4;
    localparam int V         = 2;
    localparam int ACC       = 24;
    localparam int SHIFT     = 8;
    localparam int AW        = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic              i_next_ready = 1'b1;
    logic              o_ready;
    logic [AW-1:0]     o_cim_addr;
    logic [V*ACC-1:0]  i_cim_data;
    logic              o_obuf_we;
    logic [AW-1:0]     o_obuf_addr;
    logic [DATA_SIZE-1:0] o_obuf_data;
    logic              o_next_start;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ns_cnt  = 0;

    logic signed [ACC-1:0] tiles [XBAR][V];
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];

    fc_func #(
        .DATA_SIZE   (DATA_SIZE),
        .XBAR_SIZE   (XBAR),
        .V_CIM_TILES (V),
        .ACC_WIDTH   (ACC),
        .SHIFT       (SHIFT),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .o_ready      (o_ready),
        .o_cim_addr   (o_cim_addr),
        .i_cim_data   (i_cim_data),
        .o_obuf_we    (o_obuf_we),
        .o_obuf_addr  (o_obuf_addr),
        .o_obuf_data  (o_obuf_data),
        .i_next_ready (i_next_ready),
        .o_next_start (o_next_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        i_cim_data = '0;
        for (int t = 0; t < V; t++) i_cim_data[t*ACC +: ACC] = tiles[o_cim_addr][t];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (o_obuf_we) begin
                wr_addr.push_back(int'(o_obuf_addr));
                wr_data.push_back(int'(o_obuf_data));
                wr_cyc.push_back(cyc);
            end
            if (o_next_start) ns_cnt++;
        end
    end

    // Floor-divide by 2^SHIFT, then clamp to the output range, as plain integer arithmetic.
    function automatic int model_q(longint s);
        longint q;
        longint d;
        d = longint'(1) << SHIFT;
`ifdef FC_FUNC_RELU_EN
        if (s < 0) s = 0;
        q = s / d;
        if (q > 255) q = 255;
`else
        q = s / d;
        if (s < 0 && (s % d) != 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
`endif
        return int'(q & 255);
    endfunction

    function automatic longint neuron_sum(int n);
        longint s = 0;
        for (int t = 0; t < V; t++) s += longint'(tiles[n][t]);
        return s;
    endfunction

    task automatic set_tiles_fixed(input int a, input int b);
        for (int n = 0; n < XBAR; n++) begin
            tiles[n][0] = ACC'(a);
            tiles[n][1] = ACC'(b);
        end
    endtask

    task automatic set_tiles_random();
        for (int n = 0; n < XBAR; n++)
            for (int t = 0; t < V; t++)
                if ($urandom_range(1, 0) == 1) tiles[n][t] = ACC'($urandom);
                else tiles[n][t] = ACC'(int'($urandom_range(131071, 0)) - 65536);
    endtask

    task automatic start_pulse(output int c0);
        @(posedge clk); #1;
        i_start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic check_writes(input string name, input int c0);
        int exp_d;
        n_tests++;
        if (wr_addr.size() != XBAR) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes expected %0d", name, wr_addr.size(), XBAR);
        end
        for (int i = 0; i < wr_addr.size() && i < XBAR; i++) begin
            exp_d = model_q(neuron_sum(i));
            n_tests++;
            if (wr_addr[i] !== i) begin
                n_fail++;
                $display("FAIL %s_addr%0d: got %0d expected %0d", name, i, wr_addr[i], i);
            end
            n_tests++;
            if (wr_data[i] !== exp_d) begin
                n_fail++;
                $display("FAIL %s_data%0d: got %0d expected %0d", name, i, wr_data[i], exp_d);
            end
            n_tests++;
            if (wr_cyc[i] !== c0 + 2 + 2*i) begin
                n_fail++;
                $display("FAIL %s_cycle%0d: got %0d expected %0d", name, i, wr_cyc[i] - c0, 2 + 2*i);
            end
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic run_layer(input string name);
        int c0;
        int ns0;
        clear_log();
        ns0 = ns_cnt;
        i_next_ready = 1'b1;
        start_pulse(c0);
        for (int k = 0; k < 40 && ns_cnt == ns0; k++) @(posedge clk);
        #1;
        n_tests++;
        if (ns_cnt - ns0 != 1) begin
            n_fail++;
            $display("FAIL %s_next_start: got %0d pulses expected 1", name, ns_cnt - ns0);
        end
        check_writes(name, c0);
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if ({o_ready, o_obuf_we, o_next_start} !== 3'b100 || o_cim_addr !== '0 ||
            o_obuf_addr !== '0 || o_obuf_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b we=%b ns=%b ca=%0d oa=%0d od=%0d expected rdy=1 rest 0",
                     o_ready, o_obuf_we, o_next_start, o_cim_addr, o_obuf_addr, o_obuf_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (o_ready !== 1'b1 || o_obuf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got rdy=%b we=%b expected rdy=1 we=0", o_ready, o_obuf_we);
        end
    endtask

    task automatic test_basic_layer();
        set_tiles_fixed(512, 256);
        run_layer("basic");
    endtask

    task automatic test_quant_cases();
        set_tiles_fixed(-1000, 0);
        run_layer("neg1000");
        n_tests++;
`ifdef FC_FUNC_RELU_EN
        if (wr_data.size() < 1 || wr_data[0] !== 0) begin
`else
        if (wr_data.size() < 1 || wr_data[0] !== 252) begin
`endif
            n_fail++;
            $display("FAIL neg1000_value: got %0d expected %0d", (wr_data.size() > 0) ? wr_data[0] : -1, model_q(-1000));
        end
        set_tiles_fixed(1 << 20, 0);
        run_layer("sat_pos");
        n_tests++;
`ifdef FC_FUNC_RELU_EN
        if (wr_data.size() < 1 || wr_data[0] !== 255) begin
`else
        if (wr_data.size() < 1 || wr_data[0] !== 127) begin
`endif
            n_fail++;
            $display("FAIL sat_pos_value: got %0d expected %0d", (wr_data.size() > 0) ? wr_data[0] : -1, model_q(1 << 20));
        end
        set_tiles_fixed(-(1 << 23), -(1 << 23));
        run_layer("sat_neg");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            set_tiles_random();
            run_layer($sformatf("rand%0d", r));
        end
    endtask

    task automatic test_notify_hold();
        int c0;
        int ns0;
        set_tiles_random();
        clear_log();
        ns0 = ns_cnt;
        i_next_ready = 1'b0;
        start_pulse(c0);
        for (int k = 0; k < 30 && wr_addr.size() < XBAR; k++) begin
            @(posedge clk); #1;
        end
        check_writes("hold", c0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (o_next_start !== 1'b0 || o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_wait%0d: got ns=%b rdy=%b expected ns=0 rdy=0", k, o_next_start, o_ready);
            end
        end
        i_next_ready = 1'b1;
        #1;
        n_tests++;
        if (o_next_start !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release_pulse: got %b expected 1", o_next_start);
        end
        @(posedge clk); #1;
        n_tests++;
        if (o_ready !== 1'b1 || o_next_start !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_after_pulse: got rdy=%b ns=%b expected rdy=1 ns=0", o_ready, o_next_start);
        end
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (ns_cnt - ns0 != 1) begin
            n_fail++;
            $display("FAIL hold_pulse_count: got %0d expected 1", ns_cnt - ns0);
        end
    endtask

    task automatic test_start_ignored();
        int c0;
        int ns0;
        set_tiles_random();
        clear_log();
        ns0 = ns_cnt;
        i_next_ready = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_writes("ign", c0);
        n_tests++;
        if (ns_cnt - ns0 != 1) begin
            n_fail++;
            $display("FAIL ign_next_start: got %0d expected 1", ns_cnt - ns0);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        int ns0;
        set_tiles_fixed(512, 256);
        clear_log();
        ns0 = ns_cnt;
        i_next_ready = 1'b1;
        start_pulse(c0);
        for (int k = 0; k < 30 && wr_addr.size() < 2; k++) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (wr_addr.size() != 2) begin
            n_fail++;
            $display("FAIL rstmid_pre_writes: got %0d expected 2", wr_addr.size());
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({o_ready, o_obuf_we, o_next_start} !== 3'b100 || o_cim_addr !== '0 ||
            o_obuf_addr !== '0 || o_obuf_data !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got rdy=%b we=%b ns=%b ca=%0d oa=%0d od=%0d expected rdy=1 rest 0",
                     o_ready, o_obuf_we, o_next_start, o_cim_addr, o_obuf_addr, o_obuf_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_tests++;
        if (wr_addr.size() != 2 || ns_cnt != ns0) begin
            n_fail++;
            $display("FAIL rstmid_abandon: got writes=%0d pulses=%0d expected writes=2 pulses=0",
                     wr_addr.size(), ns_cnt - ns0);
        end
        set_tiles_random();
        run_layer("after_rst");
    endtask

    initial begin
        set_tiles_fixed(0, 0);
        test_reset();
        test_basic_layer();
        test_quant_cases();
        test_random();
        test_notify_hold();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
